// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and the instruction memory.
//   imem_req   fetch side -> memory  request strobe
//   imem_addr  fetch side -> memory  word-aligned fetch address
//   imem_ack   memory -> fetch side  response strobe, imem_data valid same cycle
//   imem_data  memory -> fetch side  fetched instruction word
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues word-aligned fetches to instruction memory, tolerates any number of
// wait cycles, buffers one response while the pipeline is stalled and drains
// an in-flight request after a redirect so its data never reaches IF/ID.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en_i            IF/ID advance enable (0 = downstream stall)
//   redirect_i      taken jump/branch: refetch from redirect_pc_i
//   redirect_pc_i   redirect target (low two bits ignored)
//   imem            instruction-memory bus (master side)
//   id_inst_o       IF/ID instruction
//   id_pc_o         IF/ID address of id_inst_o
//   id_pc4_o        IF/ID id_pc_o + 4
//   id_valid_o      IF/ID holds a real instruction
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  fetch_unit_if.master imem,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        id_valid_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] hbuf_inst_q, hbuf_inst_d;
  logic [31:0] hbuf_pc_q, hbuf_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] redir_pc;
  logic [31:0] pc_plus4;
  logic [31:0] hbuf_pc_plus4;

  assign redir_pc      = redirect_pc_i & ALIGN_MASK;
  assign pc_plus4      = pc_q + 32'd4;
  assign hbuf_pc_plus4 = hbuf_pc_q + 32'd4;

  // Request is suppressed during reset so an abandoned access is not re-issued.
  assign imem.imem_req  = !rst && (state_q != HOLD);
  assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    hbuf_inst_d  = hbuf_inst_q;
    hbuf_pc_d    = hbuf_pc_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_valid_d   = id_valid_q;

    unique case (state_q)
      FETCH: begin
        if (redirect_i) begin
          pc_d       = redir_pc;
          id_valid_d = 1'b0;
          // An unanswered request must keep its address until acked, so
          // park it in drain_addr while pc moves to the new target.
          if (!imem.imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem.imem_ack) begin
          pc_d = pc_plus4;
          if (en_i) begin
            id_inst_d  = imem.imem_data;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
          end else begin
            hbuf_inst_d = imem.imem_data;
            hbuf_pc_d   = pc_q;
            state_d     = HOLD;
          end
        end else if (en_i) begin
          id_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_d        = redir_pc;
          id_valid_d  = 1'b0;
          hbuf_inst_d = '0;
          hbuf_pc_d   = '0;
          state_d     = FETCH;
        end else if (en_i) begin
          id_inst_d  = hbuf_inst_q;
          id_pc_d    = hbuf_pc_q;
          id_pc4_d   = hbuf_pc_plus4;
          id_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end

      DRAIN: begin
        if (redirect_i) begin
          pc_d       = redir_pc;
          id_valid_d = 1'b0;
        end else if (en_i) begin
          id_valid_d = 1'b0;
        end
        if (imem.imem_ack) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC & ALIGN_MASK;
      drain_addr_q <= '0;
      hbuf_inst_q  <= '0;
      hbuf_pc_q    <= '0;
      id_inst_q    <= '0;
      id_pc_q      <= '0;
      id_pc4_q     <= '0;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      hbuf_inst_q  <= hbuf_inst_d;
      hbuf_pc_q    <= hbuf_pc_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign id_inst_o  = id_inst_q;
  assign id_pc_o    = id_pc_q;
  assign id_pc4_o   = id_pc4_q;
  assign id_valid_o = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (bus),
    .id_inst_o     (id_inst),
    .id_pc_o       (id_pc),
    .id_pc4_o      (id_pc4),
    .id_valid_o    (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr;   // compared only when exp_req=1
    logic        exp_valid;
    logic        chk_id;     // compare inst/pc/pc4 after the edge
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  function automatic void add(input logic r, input logic e, input logic d,
                              input logic [31:0] rp, input logic a,
                              input logic [31:0] dt, input logic xr,
                              input logic [31:0] xa, input logic xv,
                              input logic ci, input logic [31:0] xi,
                              input logic [31:0] xp, input logic [31:0] x4);
    vec_t v;
    v.rst = r; v.en = e; v.rd = d; v.rpc = rp; v.ack = a; v.data = dt;
    v.exp_req = xr; v.exp_addr = xa; v.exp_valid = xv; v.chk_id = ci;
    v.exp_inst = xi; v.exp_pc = xp; v.exp_pc4 = x4;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic d,
                       input logic [31:0] rp, input logic a, input logic [31:0] dt);
    rst = r; en = e; redirect = d; redirect_pc = rp;
    bus.imem_ack = a; bus.imem_data = dt;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);

    //   rst en rd rpc           ack data          req addr          v  id inst          pc            pc4
    // Reset, with redirect and ack asserted (both ignored)
    add(1, 1, 1, 32'h40,       1, 32'h1111_1111, 0, 0,             0, 1, 0,             0,            0);
    add(1, 1, 0, 0,            0, 0,             0, 0,             0, 1, 0,             0,            0);
    // Zero-wait stream 0,4,8,C
    add(0, 1, 0, 0,            1, 32'hD000_0000, 1, 32'h0,         1, 1, 32'hD000_0000, 32'h0,        32'h4);
    add(0, 1, 0, 0,            1, 32'hD000_0004, 1, 32'h4,         1, 1, 32'hD000_0004, 32'h4,        32'h8);
    add(0, 1, 0, 0,            1, 32'hD000_0008, 1, 32'h8,         1, 1, 32'hD000_0008, 32'h8,        32'hC);
    add(0, 1, 0, 0,            1, 32'hD000_000C, 1, 32'hC,         1, 1, 32'hD000_000C, 32'hC,        32'h10);
    // Stall 3 cycles while ack arrives at 0x10: HOLD, IF/ID frozen
    add(0, 0, 0, 0,            1, 32'hD000_0010, 1, 32'h10,        1, 1, 32'hD000_000C, 32'hC,        32'h10);
    add(0, 0, 0, 0,            0, 0,             0, 0,             1, 1, 32'hD000_000C, 32'hC,        32'h10);
    add(0, 0, 0, 0,            0, 0,             0, 0,             1, 1, 32'hD000_000C, 32'hC,        32'h10);
    add(0, 1, 0, 0,            0, 0,             0, 0,             1, 1, 32'hD000_0010, 32'h10,       32'h14);
    // Two-wait acks: valid 0,0,1 with stable address
    add(0, 1, 0, 0,            0, 0,             1, 32'h14,        0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            0, 0,             1, 32'h14,        0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            1, 32'hD000_0014, 1, 32'h14,        1, 1, 32'hD000_0014, 32'h14,       32'h18);
    add(0, 1, 0, 0,            0, 0,             1, 32'h18,        0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            0, 0,             1, 32'h18,        0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            1, 32'hD000_0018, 1, 32'h18,        1, 1, 32'hD000_0018, 32'h18,       32'h1C);
    add(0, 1, 0, 0,            1, 32'hD000_001C, 1, 32'h1C,        1, 1, 32'hD000_001C, 32'h1C,       32'h20);
    // Redirect to 0x103 while 0x20 pending: DRAIN holds 0x20, data dropped
    add(0, 1, 0, 0,            0, 0,             1, 32'h20,        0, 0, 0,             0,            0);
    add(0, 1, 1, 32'h103,      0, 0,             1, 32'h20,        0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            0, 0,             1, 32'h20,        0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            1, BAD,           1, 32'h20,        0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            1, 32'hD000_0100, 1, 32'h100,       1, 1, 32'hD000_0100, 32'h100,      32'h104);
    // Redirect with ack in FETCH, target 0xFFFF_FFFC, then wrap to 0
    add(0, 1, 1, 32'hFFFF_FFFF,1, BAD,           1, 32'h104,       0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            1, 32'hDFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 1, 32'hDFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
    add(0, 1, 0, 0,            1, 32'hE000_0000, 1, 32'h0,         1, 1, 32'hE000_0000, 32'h0,        32'h4);
    // Redirect in HOLD with en=0: buffer dropped, valid cleared
    add(0, 0, 0, 0,            1, 32'hE000_0004, 1, 32'h4,         1, 1, 32'hE000_0000, 32'h0,        32'h4);
    add(0, 0, 1, 32'h200,      0, 0,             0, 0,             0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            1, 32'hE000_0200, 1, 32'h200,       1, 1, 32'hE000_0200, 32'h200,      32'h204);
    // Second redirect inside DRAIN updates pc only
    add(0, 1, 1, 32'h300,      0, 0,             1, 32'h204,       0, 0, 0,             0,            0);
    add(0, 1, 1, 32'h400,      0, 0,             1, 32'h204,       0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            1, BAD,           1, 32'h204,       0, 0, 0,             0,            0);
    add(0, 1, 0, 0,            1, 32'hD000_0400, 1, 32'h400,       1, 1, 32'hD000_0400, 32'h400,      32'h404);
    // Reset mid-DRAIN with redirect and ack
    add(0, 1, 1, 32'h500,      0, 0,             1, 32'h404,       0, 0, 0,             0,            0);
    add(1, 1, 1, 32'h600,      1, BAD,           0, 0,             0, 1, 0,             0,            0);
    add(0, 1, 0, 0,            1, 32'hF000_0000, 1, 32'h0,         1, 1, 32'hF000_0000, 32'h0,        32'h4);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].en, vecs[i].rd, vecs[i].rpc, vecs[i].ack, vecs[i].data);
      #1;
      chk($sformatf("v%0d req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        chk($sformatf("v%0d addr", i), bus.imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i), {31'd0, id_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].chk_id) begin
        chk($sformatf("v%0d inst", i), id_inst, vecs[i].exp_inst);
        chk($sformatf("v%0d pc", i), id_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d pc4", i), id_pc4, vecs[i].exp_pc4);
      end
    end

    // Hand sequence: stall during a wait cycle keeps IF/ID (valid=1) intact,
    // then the late ack loads 0x4 once en returns.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    #1 chk("stall_wait addr", bus.imem_addr, 32'h4);
    @(posedge clk); #1;
    chk("stall_wait valid", {31'd0, id_valid}, 32'd1);
    chk("stall_wait pc", id_pc, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hF000_0004);
    #1 chk("late_ack addr", bus.imem_addr, 32'h4);
    @(posedge clk); #1;
    chk("late_ack pc", id_pc, 32'h4);
    chk("late_ack inst", id_inst, 32'hF000_0004);

    // Hand sequence: address must stay stable across a bounded wait for ack.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("wait%0d addr", c), bus.imem_addr, 32'h8);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hF000_0008);
    @(posedge clk); #1;
    chk("wait_done pc4", id_pc4, 32'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  advance enable for the IF/ID register from the pipeline controller; 0 = downstream stall.
REQ-005 redirect  input  1  taken jump/branch/JR; 1 = refetch from redirect_pc.
REQ-006 redirect_pc  input  32  redirect target.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  word-aligned fetch address, bits [1:0] always 0.
REQ-009 imem_ack  input  1  response strobe; imem_data valid in the same cycle.
REQ-010 imem_data  input  32  fetched instruction.
REQ-011 id_inst  output  32  IF/ID register: instruction.
REQ-012 id_pc  output  32  IF/ID register: address of id_inst.
REQ-013 id_pc4  output  32  IF/ID register: id_pc+4.
REQ-014 id_valid  output  1  IF/ID register holds a real instruction.

Function
REQ-015 The block SHALL have three states: FETCH, HOLD and DRAIN.
REQ-016 FETCH: imem_req=1, imem_addr=pc; HOLD: imem_req=0; DRAIN: imem_req=1, imem_addr=drain_addr.
REQ-017 Memory protocol: once imem_req=1, imem_addr SHALL remain stable until the cycle imem_ack=1; ack may arrive in the same cycle as req (0 wait) or any later cycle.
REQ-018 FETCH, ack=1, en=1, redirect=0: IF/ID loads {imem_data, pc, pc+4, valid=1}; pc<=pc+4; stay FETCH (back-to-back request next cycle).
REQ-019 FETCH, ack=1, en=0, redirect=0: imem_data/pc captured in a one-entry hold buffer; pc<=pc+4; IF/ID unchanged; go HOLD.
REQ-020 FETCH, ack=0, en=1, redirect=0: id_valid<=0 (bubble), other IF/ID fields don't care; pc unchanged.
REQ-021 en=0 with no redirect: IF/ID register SHALL hold all fields, including id_valid.
REQ-022 HOLD, en=1: IF/ID loads hold buffer with valid=1; go FETCH; pc already points to next instruction.
REQ-023 Redirect has priority over all non-reset events; redirect_pc[1:0] SHALL be forced to 0.
REQ-024 Redirect in FETCH with ack=1: returned data discarded; pc<=redirect_pc; stay FETCH.
REQ-025 Redirect in FETCH with ack=0: drain_addr<=pc; pc<=redirect_pc; go DRAIN.
REQ-026 DRAIN: wait for ack; discard its data; go FETCH on ack; a further redirect in DRAIN updates pc only.
REQ-027 Redirect in HOLD: buffer discarded; pc<=redirect_pc; go FETCH.
REQ-028 Any redirect SHALL clear id_valid at that edge regardless of en.
REQ-029 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 A discarded response SHALL never reach the IF/ID register.

Reset
REQ-031 On rst=1 at a rising edge: state<=FETCH, pc<=RESET_PC, id_valid<=0, id_inst<=0, id_pc<=0, id_pc4<=0, hold buffer cleared; rst overrides redirect and ack.
REQ-032 During the rst=1 cycle imem_req SHALL be 0; an ack for a request abandoned by reset is ignored.
REQ-033 Cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-034 Zero-wait memory, en=1, from reset: id_pc sequence 0,4,8,12 on consecutive cycles, id_valid=1 from the second cycle after reset.
REQ-035 Ack delayed 2 cycles per fetch: id_valid pattern 0,0,1 repeating; imem_addr stable while waiting.
REQ-036 en=0 for 3 cycles while ack=1 at pc=0x10: state HOLD, imem_req=0, IF/ID frozen; en=1 -> id_pc=0x10, next fetch addr 0x14.
REQ-037 Redirect to 0x103 while ack pending at 0x20: DRAIN keeps addr 0x20 until ack, data dropped, next imem_addr=0x100, id_valid=0 throughout.
REQ-038 pc=0xFFFF_FFFC fetched with en=1: id_pc4=0, next imem_addr=0.
REQ-039 rst asserted mid-DRAIN with redirect=1: next cycle state FETCH, imem_addr=RESET_PC, id_valid=0.
